signal_ok_qualifier: RTL and testbench



---
 rtl/signal_ok_qualifier_pkg.sv | 23 ++
 rtl/signal_ok_qualifier_sat_counter.sv | 28 ++
 rtl/signal_ok_qualifier.sv | 160 ++++++++++++++++
 tb/tb_signal_ok_qualifier.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/signal_ok_qualifier_pkg.sv
// Shared definitions for the signal_ok qualifier: FSM state encoding and
// the width helper used to validate the stability counter size.
package signal_ok_qualifier_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_PEND = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_PEND = 2'd3
  } state_t;

  // Number of bits needed to hold a non-negative value (0 -> 0 bits).
  function automatic int clog2_width(input int value);
    int width = 0;
    int rest  = value;
    while (rest > 0) begin
      width++;
      rest = rest >> 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/signal_ok_qualifier_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear and an increment on
// the same edge leave the count at one.
module sat_counter #(
  parameter int NB = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [NB-1:0] count
);

  localparam logic [NB-1:0] COUNT_ONE = NB'(1);
  localparam logic [NB-1:0] COUNT_MAX = '1;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? COUNT_ONE : '0;
    end else if (inc && (count != COUNT_MAX)) begin
      count <= count + COUNT_ONE;
    end
  end

endmodule

// File: rtl/signal_ok_qualifier.sv
// Debounces a synchronized status level: o_data follows i_data only after
// N_STABLE consecutive matching samples. Optional macro SIGNAL_OK_GLITCH_CNT_EN.
module signal_ok_qualifier
  import signal_ok_qualifier_pkg::*;
#(
  parameter int N_STABLE   = 16,
  parameter int NB_COUNTER = 5,
  parameter int NB_EVENTS  = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_enable,
  input  logic                 i_data,
  input  logic                 i_clear_events,
  output logic                 o_data,
  output logic                 o_rise,
  output logic                 o_fall,
  output logic [NB_EVENTS-1:0] o_events
`ifdef SIGNAL_OK_GLITCH_CNT_EN
  ,
  output logic [NB_EVENTS-1:0] o_glitches
`endif
);

  if (N_STABLE < 1 || clog2_width(N_STABLE) > NB_COUNTER) begin : g_bad_config
    $error("signal_ok_qualifier: N_STABLE out of range for NB_COUNTER");
  end

  localparam logic [NB_COUNTER-1:0] CNT_ONE  = NB_COUNTER'(1);
  localparam logic [NB_COUNTER-1:0] CNT_LAST = NB_COUNTER'(N_STABLE - 1);

  state_t                state, state_next;
  logic [NB_COUNTER-1:0] count, count_next;
  logic                  data_next, rise_next, fall_next;
`ifdef SIGNAL_OK_GLITCH_CNT_EN
  logic                  glitch_next;
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= ST_LOW;
      count  <= '0;
      o_data <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      o_data <= data_next;
      o_rise <= rise_next;
      o_fall <= fall_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    count_next = count;
    data_next  = o_data;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
`ifdef SIGNAL_OK_GLITCH_CNT_EN
    glitch_next = 1'b0;
`endif
    if (!i_enable) begin
      // Disable drops any pending qualification without touching o_data.
      count_next = '0;
      state_next = o_data ? ST_HIGH : ST_LOW;
    end else begin
      unique case (state)
        ST_LOW: begin
          if (i_data) begin
            if (N_STABLE == 1) begin
              state_next = ST_HIGH;
              count_next = '0;
              data_next  = 1'b1;
              rise_next  = 1'b1;
            end else begin
              state_next = ST_RISE_PEND;
              count_next = CNT_ONE;
            end
          end
        end
        ST_RISE_PEND: begin
          if (!i_data) begin
            state_next = ST_LOW;
            count_next = '0;
`ifdef SIGNAL_OK_GLITCH_CNT_EN
            glitch_next = 1'b1;
`endif
          end else if (count == CNT_LAST) begin
            state_next = ST_HIGH;
            count_next = '0;
            data_next  = 1'b1;
            rise_next  = 1'b1;
          end else begin
            count_next = count + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!i_data) begin
            if (N_STABLE == 1) begin
              state_next = ST_LOW;
              count_next = '0;
              data_next  = 1'b0;
              fall_next  = 1'b1;
            end else begin
              state_next = ST_FALL_PEND;
              count_next = CNT_ONE;
            end
          end
        end
        ST_FALL_PEND: begin
          if (i_data) begin
            state_next = ST_HIGH;
            count_next = '0;
`ifdef SIGNAL_OK_GLITCH_CNT_EN
            glitch_next = 1'b1;
`endif
          end else if (count == CNT_LAST) begin
            state_next = ST_LOW;
            count_next = '0;
            data_next  = 1'b0;
            fall_next  = 1'b1;
          end else begin
            count_next = count + CNT_ONE;
          end
        end
        default: begin
          state_next = ST_LOW;
          count_next = '0;
        end
      endcase
    end
  end

  sat_counter #(
    .NB (NB_EVENTS)
  ) u_events (
    .clk   (i_clock),
    .rst_n (i_reset_n),
    .inc   (rise_next | fall_next),
    .clr   (i_clear_events),
    .count (o_events)
  );

`ifdef SIGNAL_OK_GLITCH_CNT_EN
  sat_counter #(
    .NB (NB_EVENTS)
  ) u_glitches (
    .clk   (i_clock),
    .rst_n (i_reset_n),
    .inc   (glitch_next),
    .clr   (i_clear_events),
    .count (o_glitches)
  );
`endif

endmodule

// File: tb/tb_signal_ok_qualifier.sv
// Directed bench for signal_ok_qualifier with N_STABLE=4, NB_EVENTS=2;
// glitch counter checks compile in when SIGNAL_OK_GLITCH_CNT_EN is defined.
module tb_signal_ok_qualifier;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       data_in;
  logic       clear_events;
  logic       data_out;
  logic       rise;
  logic       fall;
  logic [1:0] events;
`ifdef SIGNAL_OK_GLITCH_CNT_EN
  logic [1:0] glitches;
`endif

  int checks = 0;
  int errors = 0;

  signal_ok_qualifier #(
    .N_STABLE   (4),
    .NB_COUNTER (3),
    .NB_EVENTS  (2)
  ) dut (
    .i_clock        (clk),
    .i_reset_n      (rst_n),
    .i_enable       (enable),
    .i_data         (data_in),
    .i_clear_events (clear_events),
    .o_data         (data_out),
    .o_rise         (rise),
    .o_fall         (fall),
    .o_events       (events)
`ifdef SIGNAL_OK_GLITCH_CNT_EN
    ,
    .o_glitches     (glitches)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outputs(input string tag, input logic d, input logic r, input logic f,
                               input logic [1:0] e);
    check({tag, ".data"},   8'(data_out), 8'(d));
    check({tag, ".rise"},   8'(rise),     8'(r));
    check({tag, ".fall"},   8'(fall),     8'(f));
    check({tag, ".events"}, 8'(events),   8'(e));
  endtask

  initial begin
    logic       target;
    logic [1:0] exp_events;

    rst_n        = 1'b0;
    enable       = 1'b1;
    data_in      = 1'b0;
    clear_events = 1'b0;
    step(2);
    check_outputs("reset", 1'b0, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;
    step(1);

    // Basic rise: fourth consecutive high sample flips o_data.
    data_in = 1'b1;
    step(3);
    check_outputs("rise_pend", 1'b0, 1'b0, 1'b0, 2'd0);
    step(1);
    check_outputs("rise_edge", 1'b1, 1'b1, 1'b0, 2'd1);
    step(1);
    check_outputs("rise_after", 1'b1, 1'b0, 1'b0, 2'd1);

    // Three low samples then back high: a glitch, no transition.
    data_in = 1'b0;
    step(3);
    check_outputs("glitch_pend", 1'b1, 1'b0, 1'b0, 2'd1);
    data_in = 1'b1;
    step(1);
    check_outputs("glitch_abort", 1'b1, 1'b0, 1'b0, 2'd1);
`ifdef SIGNAL_OK_GLITCH_CNT_EN
    check("glitch_count", 8'(glitches), 8'd1);
`endif
    step(4);
    check_outputs("glitch_hold", 1'b1, 1'b0, 1'b0, 2'd1);

    // Clear with no event on the edge empties the counters.
    clear_events = 1'b1;
    step(1);
    clear_events = 1'b0;
    check("clear_events", 8'(events), 8'd0);
`ifdef SIGNAL_OK_GLITCH_CNT_EN
    check("clear_glitches", 8'(glitches), 8'd0);
`endif

    // Five qualified transitions, each level held six cycles; count saturates at 3.
    for (int i = 0; i < 5; i++) begin
      target     = (i % 2 == 1);
      exp_events = (i < 2) ? 2'(i + 1) : 2'd3;
      data_in    = target;
      step(3);
      check_outputs($sformatf("seq%0d_pend", i), ~target, 1'b0, 1'b0, (i == 0) ? 2'd0 : ((i < 3) ? 2'(i) : 2'd3));
      step(1);
      check_outputs($sformatf("seq%0d_edge", i), target, target, ~target, exp_events);
      step(2);
      check_outputs($sformatf("seq%0d_hold", i), target, 1'b0, 1'b0, exp_events);
    end

    // Clear on the same edge as a qualified fall leaves the count at one.
    data_in = 1'b1;
    step(4);
    check_outputs("sat_rise", 1'b1, 1'b1, 1'b0, 2'd3);
    data_in = 1'b0;
    step(3);
    clear_events = 1'b1;
    step(1);
    clear_events = 1'b0;
    check_outputs("clear_and_fall", 1'b0, 1'b0, 1'b1, 2'd1);
    step(1);
    check_outputs("clear_after", 1'b0, 1'b0, 1'b0, 2'd1);

    // Disable at count 3 of a rise, then re-enable with the input still high.
    data_in = 1'b1;
    step(3);
    enable = 1'b0;
    step(1);
    check_outputs("disabled_a", 1'b0, 1'b0, 1'b0, 2'd1);
    step(2);
    check_outputs("disabled_b", 1'b0, 1'b0, 1'b0, 2'd1);
    enable = 1'b1;
    step(3);
    check_outputs("reenable_pend", 1'b0, 1'b0, 1'b0, 2'd1);
    step(1);
    check_outputs("reenable_rise", 1'b1, 1'b1, 1'b0, 2'd2);
`ifdef SIGNAL_OK_GLITCH_CNT_EN
    check("enable_no_glitch", 8'(glitches), 8'd0);
`endif

    // Return low, then reset asynchronously during a rise with count 2.
    data_in = 1'b0;
    step(4);
    check_outputs("pre_reset_fall", 1'b0, 1'b0, 1'b1, 2'd3);
    step(1);
    data_in = 1'b1;
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset", 1'b0, 1'b0, 1'b0, 2'd0);
    #1;
    rst_n = 1'b1;
    step(3);
    check_outputs("post_reset_pend", 1'b0, 1'b0, 1'b0, 2'd0);
    step(1);
    check_outputs("post_reset_rise", 1'b1, 1'b1, 1'b0, 2'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
